// File: rtl/mem_stage.sv
// mem_stage: dmem request issue, outstanding-request tracking and mem/wb pipeline register
module mem_stage #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs2_rdata,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_regf_we,
  input  logic        i_wb_mux,
  input  logic        dmem_resp,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  output logic        o_issue_stall,
  output logic        o_valid,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [2:0]  o_funct3,
  output logic [31:0] o_alu_out,
  output logic [4:0]  o_rd_addr,
  output logic        o_regf_we,
  output logic        o_wb_mux,
  output logic [3:0]  o_rmask,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic        wb_mux;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        misaligned;
  } stage_t;
  state_t state_q, state_d;
  stage_t st_q, st_d;
  logic pending, mop, adv, aligned, misaligned, issue, live;
  logic [1:0] a, sz;
  logic [3:0] mask;
  assign a = i_alu_out[1:0];
  assign sz = i_funct3[1:0];
  always_comb begin
    pending = state_q == BUSY;
    mop = i_valid & (i_mem_read | i_mem_write) & ~i_flush;
    o_issue_stall = mop & pending & ~dmem_resp;
    adv = ~i_stall & ~o_issue_stall;
    aligned = !ALIGN_CHECK || sz == 2'b00 || (sz == 2'b01 ? !a[0] : a == 2'b00);
    misaligned = mop & ~aligned;
    issue = adv & mop & aligned;
    mask = sz == 2'b00 ? 4'b0001 << a : sz == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dmem_addr = {i_alu_out[31:2], 2'b00};
    dmem_rmask = issue & i_mem_read ? mask : 4'b0000;
    dmem_wmask = issue & i_mem_write ? mask : 4'b0000;
    dmem_wdata = sz == 2'b00 ? {4{i_rs2_rdata[7:0]}} : sz == 2'b01 ? {2{i_rs2_rdata[15:0]}} : i_rs2_rdata;
    // a response with no new issue retires the request; a late response while idle is a no-op
    state_d = issue ? BUSY : dmem_resp ? IDLE : state_q;
  end
  always_comb begin
    st_d = st_q;
    live = i_valid & ~i_flush & ~o_issue_stall;
    if (!i_stall) begin
      st_d.valid = live;
      st_d.mem_read = issue & i_mem_read;
      st_d.mem_write = issue & i_mem_write;
      st_d.funct3 = i_funct3;
      st_d.alu_out = i_alu_out;
      st_d.rd_addr = i_rd_addr;
      st_d.regf_we = live & ~misaligned & i_regf_we;
      st_d.wb_mux = i_wb_mux;
      st_d.rmask = dmem_rmask;
      st_d.wmask = dmem_wmask;
      st_d.wdata = dmem_wdata;
      st_d.misaligned = live & misaligned;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q <= '0;
    end else begin
      state_q <= state_d;
      st_q <= st_d;
    end
  end
  assign o_valid = st_q.valid;
  assign o_mem_read = st_q.mem_read;
  assign o_mem_write = st_q.mem_write;
  assign o_funct3 = st_q.funct3;
  assign o_alu_out = st_q.alu_out;
  assign o_rd_addr = st_q.rd_addr;
  assign o_regf_we = st_q.regf_we;
  assign o_wb_mux = st_q.wb_mux;
  assign o_rmask = st_q.rmask;
  assign o_wmask = st_q.wmask;
  assign o_wdata = st_q.wdata;
  assign o_misaligned = st_q.misaligned;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage issue, alignment, stall/flush and pending tracking
module tb_mem_stage;
  logic clk = 1'b0, rst, i_stall, i_flush, i_valid, i_mem_read, i_mem_write;
  logic [2:0] i_funct3;
  logic [31:0] i_alu_out, i_rs2_rdata;
  logic [4:0] i_rd_addr;
  logic i_regf_we, i_wb_mux, dmem_resp;
  logic [31:0] dmem_addr, dmem_wdata, o_alu_out, o_wdata;
  logic [3:0] dmem_rmask, dmem_wmask, o_rmask, o_wmask;
  logic o_issue_stall, o_valid, o_mem_read, o_mem_write, o_regf_we, o_wb_mux, o_misaligned;
  logic [2:0] o_funct3;
  logic [4:0] o_rd_addr;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_stage dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_funct3(i_funct3),
    .i_alu_out(i_alu_out), .i_rs2_rdata(i_rs2_rdata), .i_rd_addr(i_rd_addr),
    .i_regf_we(i_regf_we), .i_wb_mux(i_wb_mux), .dmem_resp(dmem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .o_issue_stall(o_issue_stall), .o_valid(o_valid),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_funct3(o_funct3),
    .o_alu_out(o_alu_out), .o_rd_addr(o_rd_addr), .o_regf_we(o_regf_we),
    .o_wb_mux(o_wb_mux), .o_rmask(o_rmask), .o_wmask(o_wmask), .o_wdata(o_wdata),
    .o_misaligned(o_misaligned)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic v, input logic r, input logic w, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] d);
    i_valid = v;
    i_mem_read = r;
    i_mem_write = w;
    i_funct3 = f3;
    i_alu_out = addr;
    i_rs2_rdata = d;
    i_regf_we = v & ~w;
    i_wb_mux = r;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0; dmem_resp = 1'b0; i_rd_addr = 5'd5;
    op(0, 0, 0, 3'b000, 32'h0, 32'h0);
    tick; tick;
    chk("rst_valid", o_valid, 0);
    chk("rst_pending", dut.pending, 0);
    chk("rst_rmask", o_rmask, 0);
    rst = 1'b0;
    op(1, 1, 0, 3'b000, 32'h0000_1003, 32'h0);
    chk("lb_addr", dmem_addr, 32'h0000_1000);
    chk("lb_rmask", dmem_rmask, 4'b1000);
    chk("lb_wmask", dmem_wmask, 4'b0000);
    tick;
    chk("lb_o_mem_read", o_mem_read, 1);
    chk("lb_o_rmask", o_rmask, 4'b1000);
    chk("lb_o_valid", o_valid, 1);
    chk("lb_pending", dut.pending, 1);
    op(0, 0, 0, 3'b000, 32'h0, 32'h0);
    dmem_resp = 1'b1; tick; dmem_resp = 1'b0;
    chk("lb_retire", dut.pending, 0);
    chk("bubble_valid", o_valid, 0);
    op(1, 0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
    chk("sh_wmask", dmem_wmask, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_rmask", dmem_rmask, 4'b0000);
    tick;
    chk("sh_pending", dut.pending, 1);
    chk("sh_o_wmask", o_wmask, 4'b1100);
    chk("sh_o_mem_write", o_mem_write, 1);
    chk("sh_o_regf_we", o_regf_we, 0);
    op(0, 0, 0, 3'b000, 32'h0, 32'h0);
    dmem_resp = 1'b1; tick; dmem_resp = 1'b0;
    chk("sh_retire", dut.pending, 0);
    op(1, 1, 0, 3'b010, 32'h0000_3002, 32'h0);
    chk("lw_mis_rmask", dmem_rmask, 4'b0000);
    chk("lw_mis_stall", o_issue_stall, 0);
    tick;
    chk("lw_mis_flag", o_misaligned, 1);
    chk("lw_mis_regf_we", o_regf_we, 0);
    chk("lw_mis_valid", o_valid, 1);
    chk("lw_mis_mem_read", o_mem_read, 0);
    chk("lw_mis_pending", dut.pending, 0);
    op(1, 1, 0, 3'b010, 32'h0000_4000, 32'h0);
    chk("b2b_first_rmask", dmem_rmask, 4'b1111);
    tick;
    chk("b2b_first_pending", dut.pending, 1);
    chk("b2b_first_mis_clr", o_misaligned, 0);
    op(1, 1, 0, 3'b100, 32'h0000_4001, 32'h0);
    for (int k = 0; k < 2; k++) begin
      chk("b2b_stall", o_issue_stall, 1);
      chk("b2b_stall_rmask", dmem_rmask, 4'b0000);
      tick;
      chk("b2b_bubble", o_valid, 0);
    end
    dmem_resp = 1'b1; #1;
    chk("b2b_resp_stall", o_issue_stall, 0);
    chk("b2b_second_rmask", dmem_rmask, 4'b0010);
    tick; dmem_resp = 1'b0;
    chk("b2b_pending", dut.pending, 1);
    chk("b2b_o_valid", o_valid, 1);
    chk("b2b_o_rmask", o_rmask, 4'b0010);
    op(0, 0, 0, 3'b000, 32'h0, 32'h0);
    dmem_resp = 1'b1; tick; dmem_resp = 1'b0;
    chk("b2b_retire", dut.pending, 0);
    op(1, 0, 1, 3'b010, 32'h0000_5000, 32'hDEAD_BEEF);
    chk("sw_wmask", dmem_wmask, 4'b1111);
    chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    tick;
    chk("sw_o_wmask", o_wmask, 4'b1111);
    i_stall = 1'b1;
    op(1, 0, 1, 3'b010, 32'h0000_5004, 32'h0BAD_F00D);
    for (int k = 0; k < 2; k++) begin
      chk("stall_no_issue", dmem_wmask, 4'b0000);
      tick;
      chk("stall_hold_wmask", o_wmask, 4'b1111);
      chk("stall_hold_addr", o_alu_out, 32'h0000_5000);
      chk("stall_hold_valid", o_valid, 1);
    end
    i_stall = 1'b0;
    op(0, 0, 0, 3'b000, 32'h0, 32'h0);
    dmem_resp = 1'b1; tick; dmem_resp = 1'b0;
    chk("sw_retire", dut.pending, 0);
    i_flush = 1'b1;
    op(1, 1, 0, 3'b010, 32'h0000_6000, 32'h0);
    chk("flush_rmask", dmem_rmask, 4'b0000);
    tick; i_flush = 1'b0;
    chk("flush_valid", o_valid, 0);
    chk("flush_o_rmask", o_rmask, 4'b0000);
    chk("flush_pending", dut.pending, 0);
    op(1, 0, 0, 3'b000, 32'h0000_0055, 32'h0);
    chk("alu_rmask", dmem_rmask, 4'b0000);
    tick;
    chk("alu_valid", o_valid, 1);
    chk("alu_regf_we", o_regf_we, 1);
    chk("alu_out", o_alu_out, 32'h0000_0055);
    chk("alu_pending", dut.pending, 0);
    op(1, 1, 0, 3'b010, 32'h0000_7000, 32'h0);
    tick;
    chk("rst_mid_pending_set", dut.pending, 1);
    rst = 1'b1;
    op(0, 0, 0, 3'b000, 32'h0, 32'h0);
    tick; rst = 1'b0;
    chk("rst_mid_pending", dut.pending, 0);
    chk("rst_mid_valid", o_valid, 0);
    dmem_resp = 1'b1; tick; dmem_resp = 1'b0;
    chk("late_resp_pending", dut.pending, 0);
    op(1, 1, 0, 3'b101, 32'h0000_8002, 32'h0);
    chk("post_rst_stall", o_issue_stall, 0);
    chk("post_rst_lhu_rmask", dmem_rmask, 4'b1100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
